// File: rtl/mxv_ctrl_if.sv
// Shared types and handshake/strobe bundle between mxv_ctrl and its datapath.
// The master side drives requests (start, in_valid, result_rd); the slave side is the controller.
package mxv_ctrl_pkg;
  typedef logic [7:0] push_pop_t;
  typedef logic [1:0] sltr_4_t;
  typedef logic       sltr_2_t;
endpackage

interface mxv_ctrl_if;
  import mxv_ctrl_pkg::*;

  logic      start;
  logic      in_valid;
  logic      in_ready;
  logic      result_rd;
  logic      push_vector;
  logic      pop_vector;
  logic      push_result;
  logic      pop_result;
  push_pop_t push_matrix;
  push_pop_t pop_matrix;
  sltr_4_t   dmx_v_sltr;
  sltr_2_t   mx_reg_sltr;
  sltr_2_t   mx_a_sltr;
  sltr_2_t   mx_b_sltr;
  sltr_2_t   mx_c_sltr;
  sltr_2_t   mx_d_sltr;
  logic      ena_proc_a;
  logic      ena_proc_b;
  logic      ena_proc_c;
  logic      ena_proc_d;
  logic [4:0] result_cnt;
  logic      busy;
  logic      done;
`ifdef MXV_CTRL_ERR_EN
  logic      error;
`endif

  modport master (
`ifdef MXV_CTRL_ERR_EN
    input  error,
`endif
    output start, in_valid, result_rd,
    input  in_ready, push_vector, pop_vector, push_result, pop_result,
    input  push_matrix, pop_matrix, dmx_v_sltr, mx_reg_sltr,
    input  mx_a_sltr, mx_b_sltr, mx_c_sltr, mx_d_sltr,
    input  ena_proc_a, ena_proc_b, ena_proc_c, ena_proc_d,
    input  result_cnt, busy, done
  );

  modport slave (
`ifdef MXV_CTRL_ERR_EN
    output error,
`endif
    input  start, in_valid, result_rd,
    output in_ready, push_vector, pop_vector, push_result, pop_result,
    output push_matrix, pop_matrix, dmx_v_sltr, mx_reg_sltr,
    output mx_a_sltr, mx_b_sltr, mx_c_sltr, mx_d_sltr,
    output ena_proc_a, ena_proc_b, ena_proc_c, ena_proc_d,
    output result_cnt, busy, done
  );
endinterface

// File: rtl/mxv_ctrl.sv
// Sequencer for a 4-stage matrix-vector pipeline: loads vector/matrix FIFOs, skews per-row pops and
// stage enables, and tracks the result FIFO. Define MXV_CTRL_ERR_EN for a sticky protocol-error flag.
module mxv_ctrl
  import mxv_ctrl_pkg::*;
#(
  parameter int N_ROWS = 8,
  parameter int N_COLS = 4
) (
  input  logic      clk,
  input  logic      rst,
  mxv_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(4 * N_ROWS);
  localparam int HALF  = N_ROWS / 2;
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(N_COLS - 1);
  localparam logic [CNT_W-1:0] MAT_LAST = CNT_W'(N_COLS * N_ROWS - 1);
  localparam logic [CNT_W-1:0] CMP_LAST = CNT_W'(N_ROWS + 5);
  localparam logic [CNT_W-1:0] MAT_HI   = CNT_W'(N_COLS * HALF);
  localparam push_pop_t         POP_ONE  = 8'd1;
  localparam logic [N_COLS-1:0] COL_ONE  = {{(N_COLS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, LOAD_V, LOAD_M, VEC, COMPUTE, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        result_cnt_q, result_cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              pop_vector_q, pop_vector_d;
  sltr_4_t           dmx_q, dmx_d;
  push_pop_t         pop_matrix_q, pop_matrix_d;
  logic [N_COLS-1:0] ena_q, ena_d;
  logic [N_COLS-1:0] mx_q, mx_d;
  logic              push_result_q, push_result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef MXV_CTRL_ERR_EN
  logic              error_q, error_d;
`endif

  logic              xfer;
  logic              push_vector;
  logic              pop_result;
  push_pop_t         push_matrix;
  logic [2:0]        mat_idx;
  int                dec_t;

  // Load strobes must coincide with the transfer, so they are gated from the live valid/rd inputs.
  always_comb begin
    xfer        = !rst && bus.in_valid && in_ready_q;
    push_vector = xfer && (state_q == LOAD_V);
    mat_idx     = {cnt_q >= MAT_HI, cnt_q[1:0]};
    push_matrix = '0;
    if (xfer && (state_q == LOAD_M)) begin
      push_matrix[mat_idx] = 1'b1;
    end
    pop_result  = !rst && bus.result_rd && (result_cnt_q != 5'd0);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    result_cnt_d = result_cnt_q + {4'd0, push_result_q} - {4'd0, pop_result};
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD_V;
          cnt_d   = '0;
        end
      end
      LOAD_V: begin
        if (xfer) begin
          if (cnt_q == COL_LAST) begin
            state_d = LOAD_M;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LOAD_M: begin
        if (xfer) begin
          if (cnt_q == MAT_LAST) begin
            state_d = VEC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      VEC: begin
        if (cnt_q == COL_LAST) begin
          state_d = COMPUTE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      COMPUTE: begin
        if (cnt_q == CMP_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in the cycle they describe.
  // In COMPUTE, row r reaches stage j at cycle r+j; its enable follows one cycle later.
  always_comb begin
    dec_t         = int'(cnt_d);
    in_ready_d    = (state_d == LOAD_V) || ((state_d == LOAD_M) && (result_cnt_d == 5'd0));
    pop_vector_d  = (state_d == VEC);
    dmx_d         = (state_d == VEC) ? cnt_d[1:0] : '0;
    pop_matrix_d  = '0;
    ena_d         = '0;
    mx_d          = '0;
    push_result_d = 1'b0;
    if (state_d == COMPUTE) begin
      for (int j = 0; j < N_COLS; j++) begin
        if ((dec_t >= j) && (dec_t - j < N_ROWS)) begin
          pop_matrix_d = pop_matrix_d | (POP_ONE << (j + ((dec_t - j >= HALF) ? N_COLS : 0)));
        end
        if ((dec_t > j) && (dec_t - j - 1 < N_ROWS)) begin
          ena_d = ena_d | (COL_ONE << j);
          if (dec_t - j - 1 >= HALF) begin
            mx_d = mx_d | (COL_ONE << j);
          end
        end
      end
      push_result_d = (dec_t >= 6) && (dec_t <= N_ROWS + 5);
    end
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

`ifdef MXV_CTRL_ERR_EN
  always_comb begin
    error_d = error_q
            | (bus.start && busy_q)
            | (bus.result_rd && (result_cnt_q == 5'd0))
            | (bus.in_valid && ((state_q == VEC) || (state_q == COMPUTE)));
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      result_cnt_q  <= '0;
      in_ready_q    <= 1'b0;
      pop_vector_q  <= 1'b0;
      dmx_q         <= '0;
      pop_matrix_q  <= '0;
      ena_q         <= '0;
      mx_q          <= '0;
      push_result_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef MXV_CTRL_ERR_EN
      error_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      result_cnt_q  <= result_cnt_d;
      in_ready_q    <= in_ready_d;
      pop_vector_q  <= pop_vector_d;
      dmx_q         <= dmx_d;
      pop_matrix_q  <= pop_matrix_d;
      ena_q         <= ena_d;
      mx_q          <= mx_d;
      push_result_q <= push_result_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
`ifdef MXV_CTRL_ERR_EN
      error_q       <= error_d;
`endif
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.push_vector = push_vector;
  assign bus.pop_vector  = pop_vector_q;
  assign bus.push_matrix = push_matrix;
  assign bus.pop_matrix  = pop_matrix_q;
  assign bus.dmx_v_sltr  = dmx_q;
  assign bus.mx_reg_sltr = 1'b0;
  assign bus.mx_a_sltr   = mx_q[0];
  assign bus.mx_b_sltr   = mx_q[1];
  assign bus.mx_c_sltr   = mx_q[2];
  assign bus.mx_d_sltr   = mx_q[3];
  assign bus.ena_proc_a  = ena_q[0];
  assign bus.ena_proc_b  = ena_q[1];
  assign bus.ena_proc_c  = ena_q[2];
  assign bus.ena_proc_d  = ena_q[3];
  assign bus.push_result = push_result_q;
  assign bus.pop_result  = pop_result;
  assign bus.result_cnt  = result_cnt_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
`ifdef MXV_CTRL_ERR_EN
  assign bus.error       = error_q;
`endif

endmodule

// File: tb/tb_mxv_ctrl.sv
// Directed bench for mxv_ctrl with N_ROWS=8: load/compute timing, backpressure, result FIFO count,
// mid-job reset and ignored starts. Expected skew tables are hand-derived for 8 rows.
module tb_mxv_ctrl;
  import mxv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  logic [7:0] exp_pm  [16];
  logic [3:0] exp_ena [16];
  logic [3:0] exp_mx  [16];

  always #5 clk = ~clk;

  mxv_ctrl_if bus();

  mxv_ctrl #(.N_ROWS(8), .N_COLS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},     32'(bus.busy), 0);
    chk({tag, "_ready"},    32'(bus.in_ready), 0);
    chk({tag, "_pm"},       32'(bus.pop_matrix), 0);
    chk({tag, "_ena"},      32'({bus.ena_proc_d, bus.ena_proc_c, bus.ena_proc_b, bus.ena_proc_a}), 0);
    chk({tag, "_mx"},       32'({bus.mx_d_sltr, bus.mx_c_sltr, bus.mx_b_sltr, bus.mx_a_sltr}), 0);
    chk({tag, "_push_res"}, 32'(bus.push_result), 0);
    chk({tag, "_pop_vec"},  32'(bus.pop_vector), 0);
    chk({tag, "_cnt"},      32'(bus.result_cnt), 0);
    chk({tag, "_done"},     32'(bus.done), 0);
  endtask

  task automatic run_job(input bit bp, input bit start_mid, input bit hold_rd, input int abort_t);
    int k = 0;
    int npush = 0;
    int c = 0;
    int m;
    logic iv;
    logic [7:0] em;
    bus.start = 1'b1;
    #2;
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_ready", 32'(bus.in_ready), 0);
    cyc();
    bus.start = 1'b0;
    while (k < 36 && c < 200) begin
      iv = !bp || (c % 2 == 0);
      bus.in_valid = iv;
      bus.start = start_mid && (c == 20);
      #2;
      m  = k - 4;
      em = (iv && k >= 4) ? (8'(1) << (m % 4 + ((m >= 16) ? 4 : 0))) : 8'd0;
      chk("load_ready", 32'(bus.in_ready), 1);
      chk("load_busy", 32'(bus.busy), 1);
      chk("push_vector", 32'(bus.push_vector), 32'(iv && k < 4));
      chk("push_matrix", 32'(bus.push_matrix), 32'(em));
      npush += int'(bus.push_vector) + $countones(bus.push_matrix);
      if (iv) k++;
      c++;
      cyc();
    end
    bus.in_valid = 1'b0;
    bus.start = 1'b0;
    chk("load_count", 32'(npush), 36);
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("vec_pop", 32'(bus.pop_vector), 1);
      chk("vec_dmx", 32'(bus.dmx_v_sltr), 32'(i));
      chk("vec_ready", 32'(bus.in_ready), 0);
      chk("vec_pm", 32'(bus.pop_matrix), 0);
      cyc();
    end
    for (int t = 0; t < 16; t++) begin
      bus.result_rd = hold_rd;
      if (t == abort_t) begin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.result_rd = 1'b0;
        #2;
        chk_all_zero("abort");
        cyc();
        return;
      end
      #2;
      chk("cmp_pop_matrix", 32'(bus.pop_matrix), 32'(exp_pm[t]));
      chk("cmp_ena", 32'({bus.ena_proc_d, bus.ena_proc_c, bus.ena_proc_b, bus.ena_proc_a}), 32'(exp_ena[t]));
      chk("cmp_mx", 32'({bus.mx_d_sltr, bus.mx_c_sltr, bus.mx_b_sltr, bus.mx_a_sltr}), 32'(exp_mx[t]));
      chk("cmp_mx_reg", 32'(bus.mx_reg_sltr), 0);
      chk("cmp_push_result", 32'(bus.push_result), 32'(t >= 6 && t <= 13));
      chk("cmp_done", 32'(bus.done), 32'(t == 14));
      chk("cmp_busy", 32'(bus.busy), 32'(t < 15));
      chk("cmp_pop_result", 32'(bus.pop_result), 32'(hold_rd && t >= 7 && t <= 14));
      if (hold_rd)
        chk("cmp_cnt_hold", 32'(bus.result_cnt), (t >= 7 && t <= 14) ? 1 : 0);
      else
        chk("cmp_cnt", 32'(bus.result_cnt), (t <= 6) ? 0 : ((t >= 14) ? 8 : t - 6));
      cyc();
    end
    bus.result_rd = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      bus.result_rd = 1'b1;
      #2;
      chk("drain_pop", 32'(bus.pop_result), 1);
      chk("drain_cnt", 32'(bus.result_cnt), 32'(n - i));
      cyc();
    end
    #2;
    chk("empty_rd_pop", 32'(bus.pop_result), 0);
    chk("empty_rd_cnt", 32'(bus.result_cnt), 0);
    cyc();
    bus.result_rd = 1'b0;
  endtask

  initial begin
    exp_pm  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E, 8'h3C, 8'h78, 8'hF0,
                8'hE0, 8'hC0, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_ena = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hF, 4'hF, 4'hF,
                4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
    exp_mx  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h3, 4'h7,
                4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.result_rd = 1'b0;
    cyc();
    cyc();
    // Reset must dominate active requests.
    bus.start = 1'b1;
    bus.in_valid = 1'b1;
    bus.result_rd = 1'b1;
    #2;
    chk("rst_pop_result", 32'(bus.pop_result), 0);
    chk("rst_push_vector", 32'(bus.push_vector), 0);
    cyc();
    rst = 1'b0;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.result_rd = 1'b0;
    #2;
    chk_all_zero("reset");
`ifdef MXV_CTRL_ERR_EN
    chk("reset_error", 32'(bus.error), 0);
`endif
    cyc();

    run_job(1'b0, 1'b0, 1'b0, -1);
`ifdef MXV_CTRL_ERR_EN
    #2;
    chk("nominal_error", 32'(bus.error), 0);
`endif
    drain(8);
`ifdef MXV_CTRL_ERR_EN
    #2;
    chk("empty_rd_error", 32'(bus.error), 1);
`endif
    rst = 1'b1;
    cyc();
    rst = 1'b0;

    run_job(1'b1, 1'b1, 1'b0, -1);
`ifdef MXV_CTRL_ERR_EN
    #2;
    chk("start_busy_error", 32'(bus.error), 1);
`endif
    drain(8);
    rst = 1'b1;
    cyc();
    rst = 1'b0;

    run_job(1'b0, 1'b0, 1'b1, -1);
    #2;
    chk("hold_final_cnt", 32'(bus.result_cnt), 0);
`ifdef MXV_CTRL_ERR_EN
    chk("hold_error", 32'(bus.error), 1);
`endif
    rst = 1'b1;
    cyc();
    rst = 1'b0;

    run_job(1'b0, 1'b0, 1'b0, 3);
    run_job(1'b0, 1'b0, 1'b0, -1);
    drain(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mxv_ctrl.md
MXV_CTRL -- requirements
Module: mxv_ctrl

Interface
REQ-001 Parameter N_ROWS, default 8, matrix rows per job; even, 2..16.
REQ-002 Parameter N_COLS, fixed 4, one column per processor stage A..D.
REQ-003 Port clk  in  1  single clock; all outputs registered on rising edge.
REQ-004 Port rst  in  1  reset, synchronous, active-high.
REQ-005 Port start  in  1  one-cycle job request; honoured only in IDLE.
REQ-006 Port in_valid  in  1  input value present on shared val bus this cycle.
REQ-007 Port in_ready  out  1  controller accepts val this cycle (transfer = in_valid && in_ready).
REQ-008 Port result_rd  in  1  consumer requests one result word.
REQ-009 Port push_vector, pop_vector, push_result, pop_result  out  1 each  datapath FIFO strobes.
REQ-010 Port push_matrix, pop_matrix  out  push_pop_t (8)  one-hot-or-zero matrix FIFO strobes.
REQ-011 Port dmx_v_sltr  out  sltr_4_t (2)  vector demux select.
REQ-012 Port mx_reg_sltr, mx_a_sltr..mx_d_sltr  out  sltr_2_t (1)  mux selects.
REQ-013 Port ena_proc_a..ena_proc_d  out  1 each  processor enables.
REQ-014 Port result_cnt  out  5  results held in result FIFO.
REQ-015 Port busy, done  out  1 each  job active; one-cycle completion pulse.

Function
REQ-016 States IDLE, LOAD_V, LOAD_M, VEC, COMPUTE, DONE; start in IDLE -> LOAD_V next cycle; start elsewhere ignored.
REQ-017 in_ready = 1 only in LOAD_V and LOAD_M, and in LOAD_M only while result_cnt = 0.
REQ-018 LOAD_V: transfers k = 0..3 assert push_vector same cycle; after 4th -> LOAD_M.
REQ-019 LOAD_M: transfer k = 0..4*N_ROWS-1 (row-major, r = k/4, j = k%4) asserts push_matrix[j + 4*(r >= N_ROWS/2)]; after last -> VEC.
REQ-020 VEC: 4 cycles, cycle i asserts pop_vector with dmx_v_sltr = i; then COMPUTE, T0 = first COMPUTE cycle.
REQ-021 COMPUTE, row r, column j, h = (r >= N_ROWS/2): pop_matrix[j+4h] at T0+r+j; matching ena_proc_x at T0+r+j+1; mx select of stage j = h during that ena cycle.
REQ-022 Several pop_matrix bits may be set in one cycle (different j); never two for same j.
REQ-023 mx_reg_sltr = 0 always (stage A starts from zero).
REQ-024 push_result at T0+r+6 per row r (D enable + register); result_cnt += 1 per push.
REQ-025 After last push_result (T0+N_ROWS+5) -> DONE for one cycle, done = 1, then IDLE.
REQ-026 busy = 1 in every state except IDLE.
REQ-027 pop_result = result_rd && result_cnt != 0, any state; result_rd at result_cnt = 0 ignored.
REQ-028 push_result and pop_result same cycle: result_cnt unchanged.
REQ-029 Strobes, enables, selects = 0 whenever not commanded above.

Reset
REQ-030 rst at clock edge, any state, including mid-LOAD or mid-COMPUTE: state = IDLE, counters = 0, result_cnt = 0, all outputs 0 next cycle.
REQ-031 Reset does not clear datapath FIFOs; the integrating block resets them with the same rst.
REQ-032 rst has priority over start, in_valid and result_rd.

Configuration
REQ-033 Macro MXV_CTRL_ERR_EN defined: output error (1 bit, sticky until rst) set on start while busy, result_rd at result_cnt = 0, or in_valid in VEC/COMPUTE.
REQ-034 Macro absent: error port not present; those events silently ignored per REQ-016/027.

Verification
REQ-035 Nominal N_ROWS=8: start, 4 vector + 32 matrix values -> 4 push_vector, push_matrix pattern per REQ-019, 8 push_result at T0+6..T0+13, done at T0+14.
REQ-036 Row 5 timing: pop_matrix[6] at T0+7, ena_proc_c at T0+8 with mx_c_sltr=1.
REQ-037 Backpressure: in_valid toggled 1/0 -> pushes only on transfer cycles, total 36, same results.
REQ-038 Reset at T0+3 -> all outputs 0 next cycle, busy=0; new job afterwards completes normally.
REQ-039 result_rd held during COMPUTE -> simultaneous push/pop keeps result_cnt; result_rd at 0 -> no pop_result (error=1 with MXV_CTRL_ERR_EN).
REQ-040 start during LOAD_M -> ignored, job unaffected; error=1 only with MXV_CTRL_ERR_EN.
